// File: rtl/fetch_pc_queue_pkg.sv
// Shared types and constants for the fetch PC sequencer and its instruction queue.
package fetch_pc_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            is_comp;
    } fetch_entry_t;

    // A parcel is compressed unless its two low opcode bits are both set.
    function automatic logic is_rvc(input logic [1:0] opcode_lo);
        return opcode_lo != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered storage head and a clearing flush.
module fetch_fifo
    import fetch_pc_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = fetch_entry_t,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    T                 mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_pc_queue.sv
// Fetch-stage PC sequencer: one request at a time to the align buffer, RVC
// classification of the returned parcel, and a small queue towards decode.
module fetch_pc_queue
    import fetch_pc_queue_pkg::*;
#(
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] UNC_BASE     = 32'h2000_0000,
    parameter logic [XLEN-1:0] UNC_LIMIT    = 32'h3FFF_FFFF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            req_valid_o,
    output logic [XLEN-1:0] req_addr_o,
    output logic            req_uncached_o,
    input  logic            res_valid_i,
    input  logic [31:0]     res_data_i,
    input  logic            buffer_miss_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_pc_o,
    output logic [31:0]     inst_o,
    output logic            inst_comp_o,
    output logic [15:0]     miss_cnt_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  pc;
    logic             active;
    logic             accept;
    logic             is_comp;
    logic             pop;
    fetch_entry_t     entry;
    fetch_entry_t     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // active holds requests off while reset is asserted and for the release cycle.
    assign req_valid_o    = active & ~flush_i & (fifo_count < CNT_W'(DEPTH));
    assign req_addr_o     = pc;
    assign req_uncached_o = (pc >= UNC_BASE) && (pc <= UNC_LIMIT);
    assign accept         = req_valid_o & res_valid_i;
    assign is_comp        = is_rvc(res_data_i[1:0]);
    assign inst_valid_o   = ~fifo_empty;
    assign pop            = inst_valid_o & inst_ready_i;
    assign inst_pc_o      = head.pc;
    assign inst_o         = head.instr;
    assign inst_comp_o    = head.is_comp;

    always_comb begin
        entry         = '0;
        entry.pc      = pc;
        entry.is_comp = is_comp;
        entry.instr   = is_comp ? {16'h0, res_data_i[15:0]} : res_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc         <= RESET_VECTOR;
            active     <= 1'b0;
            miss_cnt_o <= '0;
        end else begin
            active <= 1'b1;
            if (flush_i) begin
                pc <= flush_pc_i & ~XLEN'(1);
            end else if (accept) begin
                pc <= pc + (is_comp ? XLEN'(2) : XLEN'(4));
            end
            if (req_valid_o && buffer_miss_i && (miss_cnt_o != 16'hFFFF)) begin
                miss_cnt_o <= miss_cnt_o + 16'd1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush     (flush_i),
        .push      (accept),
        .push_data (entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A full queue must never see a request.
    assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_full |-> !req_valid_o);

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed table-driven bench for fetch_pc_queue plus a reset-mid-miss sequence.
module tb_fetch_pc_queue;

    localparam logic [31:0] A = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_uncached_o;
    logic        res_valid_i = 1'b0;
    logic [31:0] res_data_i = '0;
    logic        buffer_miss_i = 1'b0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_o;
    logic        inst_comp_o;
    logic [15:0] miss_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_pc_queue dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .req_valid_o    (req_valid_o),
        .req_addr_o     (req_addr_o),
        .req_uncached_o (req_uncached_o),
        .res_valid_i    (res_valid_i),
        .res_data_i     (res_data_i),
        .buffer_miss_i  (buffer_miss_i),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_pc_o      (inst_pc_o),
        .inst_o         (inst_o),
        .inst_comp_o    (inst_comp_o),
        .miss_cnt_o     (miss_cnt_o)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] fpc;
        logic        rv;
        logic [31:0] rd;
        logic        miss;
        logic        rdy;
        logic        erv;
        logic [31:0] eaddr;
        logic        eunc;
        logic        eiv;
        logic [31:0] eipc;
        logic [31:0] einst;
        logic        ecomp;
        logic [15:0] emiss;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic rst, input logic flush, input logic [31:0] fpc,
                               input logic rv, input logic [31:0] rd, input logic miss,
                               input logic rdy, input logic erv, input logic [31:0] eaddr,
                               input logic eunc, input logic eiv, input logic [31:0] eipc,
                               input logic [31:0] einst, input logic ecomp,
                               input logic [15:0] emiss);
        vec_t r;
        r.rst = rst; r.flush = flush; r.fpc = fpc; r.rv = rv; r.rd = rd;
        r.miss = miss; r.rdy = rdy; r.erv = erv; r.eaddr = eaddr; r.eunc = eunc;
        r.eiv = eiv; r.eipc = eipc; r.einst = einst; r.ecomp = ecomp; r.emiss = emiss;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_valid"},  32'(req_valid_o),    32'd0);
        chk({tag, " req_addr"},   req_addr_o,          A);
        chk({tag, " uncached"},   32'(req_uncached_o), 32'd0);
        chk({tag, " inst_valid"}, 32'(inst_valid_o),   32'd0);
        chk({tag, " inst_pc"},    inst_pc_o,           32'd0);
        chk({tag, " inst"},       inst_o,              32'd0);
        chk({tag, " inst_comp"},  32'(inst_comp_o),    32'd0);
        chk({tag, " miss_cnt"},   32'(miss_cnt_o),     32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_i = 1'b0; flush_pc_i = '0; res_valid_i = 1'b0; res_data_i = '0;
        buffer_miss_i = 1'b0; inst_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sequential hits, decode always ready
        vq.push_back(v(1,0,0,1,32'h13,0,1, 1,A,     0, 0,0,0,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,1, 1,A+4,   0, 1,A,32'h13,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,1, 1,A+8,   0, 1,A+4,32'h13,0, 0));
        vq.push_back(v(0,0,0,0,0,     0,1, 1,A+12,  0, 1,A+8,32'h13,0, 0));
        vq.push_back(v(0,0,0,0,0,     0,1, 1,A+12,  0, 0,0,0,0, 0));
        // RVC then 32b; RVC upper half must be zeroed
        vq.push_back(v(1,0,0,1,32'hFFFF_4501,0,1, 1,A,   0, 0,0,0,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,       0,1, 1,A+2, 0, 1,A,32'h4501,1, 0));
        vq.push_back(v(0,0,0,0,0,            0,1, 1,A+6, 0, 1,A+2,32'h13,0, 0));
        vq.push_back(v(0,0,0,0,0,            0,1, 1,A+6, 0, 0,0,0,0, 0));
        // Decode stalled: fill to DEPTH, then drain in order
        vq.push_back(v(1,0,0,1,32'h13,0,0, 1,A,      0, 0,0,0,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,0, 1,A+4,    0, 1,A,32'h13,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,0, 1,A+8,    0, 1,A,32'h13,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,0, 1,A+12,   0, 1,A,32'h13,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,0, 0,A+16,   0, 1,A,32'h13,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,0, 0,A+16,   0, 1,A,32'h13,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,1, 0,A+16,   0, 1,A,32'h13,0, 0));
        vq.push_back(v(0,0,0,1,32'h13,0,1, 1,A+16,   0, 1,A+4,32'h13,0, 0));
        vq.push_back(v(0,0,0,0,0,     0,1, 1,A+20,   0, 1,A+8,32'h13,0, 0));
        vq.push_back(v(0,0,0,0,0,     0,1, 1,A+20,   0, 1,A+12,32'h13,0, 0));
        vq.push_back(v(0,0,0,0,0,     0,1, 1,A+20,   0, 1,A+16,32'h13,0, 0));
        vq.push_back(v(0,0,0,0,0,     0,1, 1,A+20,   0, 0,0,0,0, 0));
        // Miss for 5 cycles, then hit
        vq.push_back(v(1,0,0,0,0,     1,1, 1,A,   0, 0,0,0,0, 0));
        vq.push_back(v(0,0,0,0,0,     1,1, 1,A,   0, 0,0,0,0, 1));
        vq.push_back(v(0,0,0,0,0,     1,1, 1,A,   0, 0,0,0,0, 2));
        vq.push_back(v(0,0,0,0,0,     1,1, 1,A,   0, 0,0,0,0, 3));
        vq.push_back(v(0,0,0,0,0,     1,1, 1,A,   0, 0,0,0,0, 4));
        vq.push_back(v(0,0,0,1,32'h13,0,1, 1,A,   0, 0,0,0,0, 5));
        vq.push_back(v(0,0,0,0,0,     0,1, 1,A+4, 0, 1,A,32'h13,0, 5));
        // Flush with a colliding response, then back-to-back flushes
        vq.push_back(v(1,0,0,             1,32'h13,  0,0, 1,A,      0, 0,0,0,0, 0));
        vq.push_back(v(0,1,32'h8000_0103, 1,32'h13,  0,0, 0,A+4,    0, 1,A,32'h13,0, 0));
        vq.push_back(v(0,0,0,             0,0,       0,0, 1,A+32'h102, 0, 0,0,0,0, 0));
        vq.push_back(v(0,0,0,             1,32'h4501,0,0, 1,A+32'h102, 0, 0,0,0,0, 0));
        vq.push_back(v(0,1,32'h8000_0200, 0,0,       0,0, 0,A+32'h104, 0, 1,A+32'h102,32'h4501,1, 0));
        vq.push_back(v(0,1,32'h8000_0300, 1,32'h13,  0,0, 0,A+32'h200, 0, 0,0,0,0, 0));
        vq.push_back(v(0,0,0,             0,0,       0,0, 1,A+32'h300, 0, 0,0,0,0, 0));
        // Uncached window edges and PC wrap
        vq.push_back(v(1,1,32'h1FFF_FFFF,0,0,0,0, 0,A,            0, 0,0,0,0, 0));
        vq.push_back(v(0,1,32'h2000_0000,0,0,0,0, 0,32'h1FFF_FFFE, 0, 0,0,0,0, 0));
        vq.push_back(v(0,1,32'h3FFF_FFFF,0,0,0,0, 0,32'h2000_0000, 1, 0,0,0,0, 0));
        vq.push_back(v(0,1,32'h4000_0000,0,0,0,0, 0,32'h3FFF_FFFE, 1, 0,0,0,0, 0));
        vq.push_back(v(0,1,32'hFFFF_FFFF,0,0,0,0, 0,32'h4000_0000, 0, 0,0,0,0, 0));
        vq.push_back(v(0,0,0,1,32'h4501, 0,1, 1,32'hFFFF_FFFE, 0, 0,0,0,0, 0));
        vq.push_back(v(0,0,0,0,0,        0,1, 1,32'h0,         0, 1,32'hFFFF_FFFE,32'h4501,1, 0));
        vq.push_back(v(0,0,0,0,0,        0,1, 1,32'h0,         0, 0,0,0,0, 0));

        #2 rst_n = 1'b0;
        #1 chk_reset("reset");

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) do_reset();
            flush_i       = vq[i].flush;
            flush_pc_i    = vq[i].fpc;
            res_valid_i   = vq[i].rv;
            res_data_i    = vq[i].rd;
            buffer_miss_i = vq[i].miss;
            inst_ready_i  = vq[i].rdy;
            #3;
            chk($sformatf("v%0d req_valid", i),  32'(req_valid_o),    32'(vq[i].erv));
            chk($sformatf("v%0d req_addr", i),   req_addr_o,          vq[i].eaddr);
            chk($sformatf("v%0d uncached", i),   32'(req_uncached_o), 32'(vq[i].eunc));
            chk($sformatf("v%0d inst_valid", i), 32'(inst_valid_o),   32'(vq[i].eiv));
            chk($sformatf("v%0d miss_cnt", i),   32'(miss_cnt_o),     32'(vq[i].emiss));
            if (vq[i].eiv) begin
                chk($sformatf("v%0d inst_pc", i),   inst_pc_o,        vq[i].eipc);
                chk($sformatf("v%0d inst", i),      inst_o,           vq[i].einst);
                chk($sformatf("v%0d inst_comp", i), 32'(inst_comp_o), 32'(vq[i].ecomp));
            end
            @(posedge clk);
            #1;
        end

        // Reset asserted asynchronously in the middle of a miss
        do_reset();
        res_valid_i = 1'b1; res_data_i = 32'h13; inst_ready_i = 1'b0;
        @(posedge clk);
        #1 res_valid_i = 1'b0; buffer_miss_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midmiss miss_cnt",   32'(miss_cnt_o),   32'd3);
        chk("midmiss inst_valid", 32'(inst_valid_o), 32'd1);
        chk("midmiss req_addr",   req_addr_o,        A + 32'd4);
        #2 rst_n = 1'b0;
        #1 chk_reset("midmiss reset");
        buffer_miss_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
